lsu_sequencer: RTL and testbench
================================

Name: lsu_sequencer

Overview:
- Multi-cycle sequencer for the data-memory port, driven by the decoder's memory_en / store_size / funct3 outputs.
- Turns one load or store into a req/ready transaction on a word-addressed memory, with byte-lane alignment and load sign/zero extension.
- Stalls the core until the access completes and flags misaligned accesses and bus timeouts.
- Sits between decode/execute (ALU result is the address) and the data memory; its load result feeds the register-file write mux (wdSelect = "01").

Parameters:
- TIMEOUT, default 16: maximum number of REQ cycles waiting for mem_ready before a bus error.
- XLEN, default 32: data/address width; only 32 is supported.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- memory_en  in  1  current instruction accesses memory.
- store_size  in  2  00 byte, 01 half, 10 word, 11 load.
- funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (rs2).
- stall  out  1  hold fetch/decode and PC this cycle.
- load_valid  out  1  one-cycle pulse; load_data valid.
- load_data  out  32  aligned, extended load result.
- err_misaligned  out  1  access not naturally aligned; access suppressed.
- err_bus  out  1  one-cycle pulse on timeout.
- mem_req  out  1  transaction request.
- mem_we  out  1  1 store, 0 load.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_wmask  out  4  byte-lane enables (0000 for loads).
- mem_wdata  out  32  store data shifted to its lanes.
- mem_rdata  in  32  read word.
- mem_ready  in  1  completes the transaction when sampled with mem_req=1.

Behaviour:
- Reset: state IDLE, timeout counter 0. All outputs are 0 (mem_req, mem_we, mem_wmask, load_valid, load_data, err_*, stall).
- Reset mid-transaction: next cycle is IDLE and mem_req=0. Any captured data is discarded and no load_valid is produced.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - If memory_en and aligned: capture addr, wdata, store_size, funct3; go to REQ; stall=1 this cycle (combinational).
  - If memory_en and misaligned: err_misaligned=1 (combinational), stall=0, no transaction, stay in IDLE.
  - Otherwise stall=0.
- Misaligned means: half with addr[0]=1, or word with addr[1:0]!=0. The load size is taken from funct3[1:0].
- REQ:
  - mem_req=1. mem_addr, mem_we, mem_wmask and mem_wdata are driven from registers and held stable until completion. stall=1.
  - If mem_ready=1: for a load, register the formatted mem_rdata; go to DONE.
  - Else if the counter equals TIMEOUT-1: go to DONE with error latched.
  - Otherwise increment the counter.
- DONE:
  - stall=0. The instruction retires this cycle; the counter clears.
  - load_valid=1 for loads without error. err_bus=1 if a timeout occurred, with load_data=0 and load_valid=0.
  - Next state is IDLE.
- Minimum latency: 3 cycles (IDLE→REQ→DONE) with mem_ready asserted on the first REQ cycle.
- Store lanes, indexed by off = addr[1:0]:
  - byte: wmask = 0001<<off, wdata replicated to all 4 bytes.
  - half: wmask = 0011<<off, wdata half replicated to both halves.
  - word: wmask = 1111.
- Load extract: byte/half selected by off. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Undefined load funct3 (011, 110, 111): treated as LW.
- mem_ready while mem_req=0: ignored.
- load_data holds its value until the next load completes.

Decomposition:
- core_pkg holds:
  - the store_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_LOAD);
  - the load funct3 codes;
  - the lsu_state_t enum {IDLE, REQ, DONE}.
- One combinational sub-module, lsu_align, contains the store mask/data shifting and the load extract/extend. The FSM, registers and timeout counter stay in lsu_sequencer.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, mem_ready on the 1st REQ cycle → mem_addr=0x100, wmask=1111, wdata=0xDEADBEEF, stall high for 2 cycles, DONE on cycle 3.
- SB addr=0x103, wdata=0x000000A5 → wmask=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x100.
- LB addr=0x202, mem_rdata=0x12F03456, ready delayed 4 cycles → mem_req held 5 cycles with stable address, load_data=0xFFFFFFF0, load_valid single pulse. Repeat as LBU → 0x000000F0.
- LH addr=0x301 → err_misaligned=1 in the same cycle, stall=0, mem_req never asserted.
- LW with mem_ready held low for 16 cycles → err_bus pulse in DONE, load_valid=0, return to IDLE. Then an immediate SW completes normally.
- reset asserted in the 2nd REQ cycle of an LW → mem_req=0 the next cycle, state IDLE, no load_valid.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the load/store unit: decoder store_size codes,
// load funct3 codes and the sequencer state type.
package core_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_LOAD = 2'b11;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  // Size uses store_size encoding; 2'b11 (odd load funct3) is treated as a word.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = off[0];
      default: mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and lane extract plus sign/zero extension
// for loads against a 32-bit word-addressed memory. Purely combinational.
module lsu_align
  import core_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  store_size,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wmask = 4'b0000;
    case (store_size)
      SZ_BYTE: wmask = 4'b0001 << off;
      SZ_HALF: wmask = 4'b0011 << off;
      SZ_WORD: wmask = 4'b1111;
      default: wmask = 4'b0000;
    endcase
  end

  // Replicating the narrow datum into every lane lets the mask alone pick the target.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata[8*gi +: 8] = (store_size == SZ_BYTE) ? store_data[7:0] :
                              (store_size == SZ_HALF) ? store_data[8*(gi%2) +: 8] :
                                                        store_data[8*gi +: 8];
  end

  assign byte_sel = rdata[{off, 3'b000} +: 8];
  assign half_sel = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  load_data = {24'h000000, byte_sel};
      F3_LHU:  load_data = {16'h0000, half_sel};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_sequencer.sv
// Data-memory port sequencer: turns one decoded load/store into a req/ready
// transaction, stalls the core meanwhile, and reports misalignment and timeouts.
module lsu_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            memory_en,
  input  logic [1:0]      store_size,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic            load_valid,
  output logic [XLEN-1:0] load_data,
  output logic            err_misaligned,
  output logic            err_bus,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wmask,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [XLEN-1:0] addr_reg, wdata_reg, load_data_reg;
  logic [1:0]      size_reg;
  logic [2:0]      funct3_reg;
  logic            err_reg;

  logic [1:0]      access_size;
  logic            misaligned;
  logic            is_load;
  logic [3:0]      align_wmask;
  logic [31:0]     align_wdata, align_load;

  assign access_size = (store_size == SZ_LOAD) ? funct3[1:0] : store_size;
  assign misaligned  = is_misaligned(access_size, addr[1:0]);
  assign is_load     = (size_reg == SZ_LOAD);

  lsu_align u_align (
    .off        (addr_reg[1:0]),
    .store_size (size_reg),
    .store_data (wdata_reg),
    .funct3     (funct3_reg),
    .rdata      (mem_rdata),
    .wmask      (align_wmask),
    .wdata      (align_wdata),
    .load_data  (align_load)
  );

  always_comb begin
    state_next     = state_reg;
    stall          = 1'b0;
    err_misaligned = 1'b0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_wmask      = 4'b0000;
    mem_wdata      = '0;
    load_valid     = 1'b0;
    err_bus        = 1'b0;
    load_data      = load_data_reg;
    case (state_reg)
      IDLE: begin
        if (memory_en) begin
          if (misaligned) begin
            err_misaligned = 1'b1;
          end else begin
            stall      = 1'b1;
            state_next = REQ;
          end
        end
      end
      REQ: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = !is_load;
        mem_addr  = {addr_reg[XLEN-1:2], 2'b00};
        mem_wmask = is_load ? 4'b0000 : align_wmask;
        mem_wdata = align_wdata;
        if (mem_ready || (cnt_reg == CNT_LAST)) state_next = DONE;
      end
      DONE: begin
        load_valid = is_load && !err_reg;
        err_bus    = err_reg;
        if (err_reg) load_data = '0;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      size_reg      <= SZ_BYTE;
      funct3_reg    <= 3'b000;
      err_reg       <= 1'b0;
      load_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          cnt_reg <= '0;
          err_reg <= 1'b0;
          if (memory_en && !misaligned) begin
            addr_reg   <= addr;
            wdata_reg  <= wdata;
            size_reg   <= store_size;
            funct3_reg <= funct3;
          end
        end
        REQ: begin
          if (mem_ready) begin
            if (is_load) load_data_reg <= align_load;
          end else if (cnt_reg == CNT_LAST) begin
            err_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          cnt_reg <= '0;
          err_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_sequencer.sv
// Directed bench for lsu_sequencer: stores, loads with wait states,
// misalignment, bus timeout and reset in the middle of a transaction.
module tb_lsu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_en;
  logic [1:0]  store_size;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_ready;
  logic        stall, load_valid, err_misaligned, err_bus, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .memory_en      (memory_en),
    .store_size     (store_size),
    .funct3         (funct3),
    .addr           (addr),
    .wdata          (wdata),
    .stall          (stall),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .err_misaligned (err_misaligned),
    .err_bus        (err_bus),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wmask      (mem_wmask),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .mem_ready      (mem_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Starts and ends on a falling edge with the sequencer in IDLE.
  task automatic run_txn(input string tag, input logic [1:0] sz, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                         input int delay, input logic [3:0] exp_mask, input logic [31:0] exp_wdata,
                         input logic exp_lv, input logic [31:0] exp_ld);
    logic is_st;
    is_st = (sz != 2'b11);
    memory_en = 1'b1; store_size = sz; funct3 = f3; addr = a; wdata = wd;
    #1;
    chk({tag, "_idle_stall"}, stall, 1);
    chk({tag, "_idle_req"}, mem_req, 0);
    step();
    memory_en = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
    for (int i = 0; i <= delay; i++) begin
      mem_ready = (i == delay);
      mem_rdata = (i == delay) ? rd : 32'h0BAD_0BAD;
      #1;
      chk({tag, "_req"}, mem_req, 1);
      chk({tag, "_req_stall"}, stall, 1);
      chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
      chk({tag, "_we"}, mem_we, is_st);
      chk({tag, "_wmask"}, mem_wmask, exp_mask);
      if (is_st) chk({tag, "_wdata"}, mem_wdata, exp_wdata);
      step();
    end
    mem_ready = 1'b0;
    #1;
    chk({tag, "_done_stall"}, stall, 0);
    chk({tag, "_done_req"}, mem_req, 0);
    chk({tag, "_done_errbus"}, err_bus, 0);
    chk({tag, "_done_lv"}, load_valid, exp_lv);
    if (exp_lv) chk({tag, "_done_ld"}, load_data, exp_ld);
    step();
    #1;
    chk({tag, "_after_lv"}, load_valid, 0);
    if (exp_lv) chk({tag, "_after_ld_hold"}, load_data, exp_ld);
  endtask

  initial begin
    reset = 1'b1; memory_en = 1'b0; store_size = 2'b00; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_wmask", mem_wmask, 0);
    chk("rst_lv", load_valid, 0);
    chk("rst_ld", load_data, 0);
    chk("rst_errmis", err_misaligned, 0);
    chk("rst_errbus", err_bus, 0);
    reset = 1'b0;
    step();

    run_txn("sw",  2'b10, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0);
    run_txn("sb",  2'b00, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 4'b1000, 32'hA5A5_A5A5, 1'b0, 32'h0);
    run_txn("sh",  2'b01, 3'b001, 32'h0000_0102, 32'hABCD_1234, 32'h0, 0, 4'b1100, 32'h1234_1234, 1'b0, 32'h0);
    run_txn("lb",  2'b11, 3'b000, 32'h0000_0202, 32'h0, 32'h12F0_3456, 4, 4'b0000, 32'h0, 1'b1, 32'hFFFF_FFF0);
    run_txn("lbu", 2'b11, 3'b100, 32'h0000_0202, 32'h0, 32'h12F0_3456, 4, 4'b0000, 32'h0, 1'b1, 32'h0000_00F0);
    run_txn("lh",  2'b11, 3'b001, 32'h0000_0302, 32'h0, 32'h8001_1234, 1, 4'b0000, 32'h0, 1'b1, 32'hFFFF_8001);
    run_txn("lhu", 2'b11, 3'b101, 32'h0000_0300, 32'h0, 32'h1234_8001, 0, 4'b0000, 32'h0, 1'b1, 32'h0000_8001);
    run_txn("lw",  2'b11, 3'b010, 32'h0000_0204, 32'h0, 32'h89AB_CDEF, 2, 4'b0000, 32'h0, 1'b1, 32'h89AB_CDEF);
    run_txn("f3_011", 2'b11, 3'b011, 32'h0000_0208, 32'h0, 32'h0F0F_00F0, 0, 4'b0000, 32'h0, 1'b1, 32'h0F0F_00F0);

    // Misaligned LH: flagged combinationally, no transaction started
    memory_en = 1'b1; store_size = 2'b11; funct3 = 3'b001; addr = 32'h0000_0301;
    #1;
    chk("mis_lh_err", err_misaligned, 1);
    chk("mis_lh_stall", stall, 0);
    chk("mis_lh_req", mem_req, 0);
    step();
    memory_en = 1'b0;
    #1;
    chk("mis_lh_req_next", mem_req, 0);
    chk("mis_lh_err_next", err_misaligned, 0);
    memory_en = 1'b1; store_size = 2'b10; addr = 32'h0000_0102;
    #1;
    chk("mis_sw_err", err_misaligned, 1);
    step();
    memory_en = 1'b0;
    #1;
    chk("mis_sw_req_next", mem_req, 0);

    // LW with no ready: 16 REQ cycles then a bus error
    memory_en = 1'b1; store_size = 2'b11; funct3 = 3'b010; addr = 32'h0000_0400;
    #1;
    chk("to_idle_stall", stall, 1);
    step();
    memory_en = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_req", mem_req, 1);
      step();
    end
    #1;
    chk("to_errbus", err_bus, 1);
    chk("to_lv", load_valid, 0);
    chk("to_ld", load_data, 0);
    chk("to_stall", stall, 0);
    chk("to_req_done", mem_req, 0);
    step();
    #1;
    chk("to_errbus_after", err_bus, 0);
    run_txn("sw2", 2'b10, 3'b010, 32'h0000_0104, 32'h1122_3344, 32'h0, 0, 4'b1111, 32'h1122_3344, 1'b0, 32'h0);

    // Reset in the 2nd REQ cycle of an LW
    memory_en = 1'b1; store_size = 2'b11; funct3 = 3'b010; addr = 32'h0000_0500;
    step();
    memory_en = 1'b0;
    #1;
    chk("rmid_req1", mem_req, 1);
    step();
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
    #1;
    chk("rmid_req2", mem_req, 1);
    step();
    reset = 1'b0; mem_ready = 1'b0;
    #1;
    chk("rmid_req_after", mem_req, 0);
    chk("rmid_stall_after", stall, 0);
    chk("rmid_lv_after", load_valid, 0);
    chk("rmid_ld_after", load_data, 0);
    mem_ready = 1'b1;
    step();
    #1;
    chk("rmid_lv_next", load_valid, 0);
    chk("rmid_idle_ready_ignored", mem_req, 0);
    mem_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
